mult64_sched: RTL

- Shares one ce-gated 64x64 Karatsuba multiplier (mult64x64, 11-cycle latency) between NREQ requesters.
- Requesters are arbitrated round-robin, with at most one issue per cycle.
- Signed operands are converted to magnitudes before the multiplier, and the sign is reapplied after it.
- Each in-flight operation carries a requester id and sign tag through a shadow pipeline. A single output register carries valid/ready backpressure, and backpressure stalls the whole pipeline.
- Sits between the FPU/integer issue ports and the shared multiplier.

---
 rtl/mult64_sched_pkg.sv | 28 ++
 rtl/mult64_sched_if.sv | 23 ++
 rtl/mult64_sched_tag_pipe.sv | 23 ++
 rtl/mult64x64.sv | 28 ++
 rtl/mult64_sched.sv | 72 +++++++
 5 files changed

// File: rtl/mult64_sched_pkg.sv
// mult_sched_pkg: shared types, latencies and helpers for the multiplier scheduler.
package mult_sched_pkg;
    localparam int MUL_LAT = 11;
    localparam int SCHED_LAT = MUL_LAT + 2;
    localparam int TAG_IDW = 3;

    typedef struct packed {
        logic                v;
        logic [TAG_IDW-1:0]  id;
        logic                neg;
    } sched_tag_t;

    // First requester at or after ptr+1 (mod n), one-hot; zero when nobody asks.
    function automatic logic [7:0] rr_pick(input logic [7:0] req, input logic [TAG_IDW-1:0] ptr, input int n);
        logic [7:0] g;
        int idx;
        g = '0;
        for (int k = 1; k <= 8; k++) begin
            idx = (int'(ptr) + k) % n;
            if (k <= n && g == '0 && req[idx[2:0]]) g[idx[2:0]] = 1'b1;
        end
        return g;
    endfunction

    function automatic logic [63:0] mag(input logic [63:0] x, input logic sgn);
        return (sgn && x[63]) ? -x : x;
    endfunction
endpackage

// File: rtl/mult64_sched_if.sv
// mult64_sched_if: requester and result handshake bundle of the multiplier scheduler.
interface mult64_sched_if #(parameter int NREQ = 4, parameter int IDW = $clog2(NREQ));
    logic [NREQ-1:0]    req_v;
    logic [NREQ-1:0]    req_rdy;
    logic [NREQ-1:0]    req_sgn;
    logic [NREQ*64-1:0] req_a;
    logic [NREQ*64-1:0] req_b;
    logic               res_v;
    logic               res_rdy;
    logic [IDW-1:0]     res_id;
    logic [127:0]       res_p;
    logic [3:0]         inflight;
    logic               idle;

    modport master (
        output req_v, req_sgn, req_a, req_b, res_rdy,
        input  req_rdy, res_v, res_id, res_p, inflight, idle
    );
    modport slave (
        input  req_v, req_sgn, req_a, req_b, res_rdy,
        output req_rdy, res_v, res_id, res_p, inflight, idle
    );
endinterface

// File: rtl/mult64_sched_tag_pipe.sv
// mult_tag_pipe: ce-gated shadow shift register carrying {v,id,neg} beside the multiplier.
module mult_tag_pipe
    import mult_sched_pkg::*;
#(
    parameter int DEPTH = MUL_LAT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ce,
    input  sched_tag_t d,
    output sched_tag_t q
);
    sched_tag_t sr [DEPTH];

    always_ff @(posedge clk or posedge rst)
        if (rst) for (int i = 0; i < DEPTH; i++) sr[i] <= '0;
        else if (ce) begin
            sr[0] <= d;
            for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
        end

    assign q = sr[DEPTH-1];
endmodule

// File: rtl/mult64x64.sv
// mult64x64: ce-gated 64x64 unsigned Karatsuba multiplier, 11-cycle latency.
module mult64x64 (
    input  logic         clk,
    input  logic         ce,
    input  logic [63:0]  a,
    input  logic [63:0]  b,
    output logic [127:0] p
);
    logic [32:0]  sa, sb;
    logic [63:0]  z0, z2;
    logic [65:0]  z1;
    logic [127:0] pl [10];

    assign sa = {1'b0, a[63:32]} + {1'b0, a[31:0]};
    assign sb = {1'b0, b[63:32]} + {1'b0, b[31:0]};

    // z1 - z2 - z0 is the cross term ah*bl + al*bh, always non-negative.
    always_ff @(posedge clk)
        if (ce) begin
            z0 <= 64'(a[31:0]) * 64'(b[31:0]);
            z2 <= 64'(a[63:32]) * 64'(b[63:32]);
            z1 <= 66'(sa) * 66'(sb);
            pl[0] <= {z2, z0} + ({62'b0, z1 - {2'b0, z2} - {2'b0, z0}} << 32);
            for (int i = 1; i < 10; i++) pl[i] <= pl[i-1];
        end

    assign p = pl[9];
endmodule

// File: rtl/mult64_sched.sv
// mult64_sched: round-robin scheduler sharing one signed/unsigned 64x64 multiplier
// among NREQ requesters, with a single backpressured output register.
module mult64_sched
    import mult_sched_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ),
    parameter int MLAT = MUL_LAT
) (
    input logic clk,
    input logic rst,
    mult64_sched_if.slave bus
);
    logic            stall, ce, acc, sgn_sel;
    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  ptr, sel;
    logic [63:0]     a_sel, b_sel, ia, ib;
    logic [127:0]    prod;
    sched_tag_t      itag, otag;

    assign stall = bus.res_v & ~bus.res_rdy;
    assign ce = ~stall;
    assign grant = NREQ'(rr_pick(8'(bus.req_v), TAG_IDW'(ptr), NREQ));
    assign bus.req_rdy = (ce && !rst) ? grant : '0;
    assign acc = |(bus.req_v & bus.req_rdy);

    always_comb begin
        sel = '0;
        for (int i = 0; i < NREQ; i++) if (grant[i]) sel = IDW'(i);
    end

    assign a_sel = bus.req_a[64*sel +: 64];
    assign b_sel = bus.req_b[64*sel +: 64];
    assign sgn_sel = bus.req_sgn[sel];

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            ptr <= IDW'(NREQ - 1);
            itag <= '0;
        end else if (ce) begin
            itag <= '{v: acc, id: TAG_IDW'(sel), neg: sgn_sel & (a_sel[63] ^ b_sel[63])};
            if (acc) ptr <= sel;
        end

    // Operand magnitudes need no reset: the tag valid bit qualifies them.
    always_ff @(posedge clk)
        if (ce && acc) begin
            ia <= mag(a_sel, sgn_sel);
            ib <= mag(b_sel, sgn_sel);
        end

    mult64x64 u_mul (.clk(clk), .ce(ce), .a(ia), .b(ib), .p(prod));

    mult_tag_pipe #(.DEPTH(MLAT)) u_tags (.clk(clk), .rst(rst), .ce(ce), .d(itag), .q(otag));

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            bus.res_v <= 1'b0;
            bus.res_id <= '0;
            bus.res_p <= '0;
            bus.inflight <= '0;
        end else begin
            if (ce) begin
                bus.res_v <= otag.v;
                bus.res_id <= IDW'(otag.id);
                bus.res_p <= otag.neg ? -prod : prod;
            end
            bus.inflight <= bus.inflight + 4'(acc) - 4'(bus.res_v & bus.res_rdy);
        end

    assign bus.idle = bus.inflight == 4'd0;
endmodule
